// File: rtl/hilo_mult_unit.sv
`timescale 1ns/1ps
// hilo_mult_unit
// Takes MULT/MULTU/MTHI/MTLO from the execute stage and drives an external
// unsigned 32x32 multiplier core. It waits out the core latency, applies the
// sign correction and commits the 64-bit product to HI/LO.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | no multiply in flight; MTHI/MTLO write directly; MULT* issue
// ST_WAIT   | operands held on core_a/core_b; cnt counts down the core latency
// ST_COMMIT | core_z is valid; sign-corrected product is written to HI/LO
module hilo_mult_unit #(
    parameter int unsigned LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        op_valid,
    input  logic [1:0]  op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    output logic [31:0] core_a,
    output logic [31:0] core_b,
    input  logic [63:0] core_z,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [1:0] OP_MULTU = 2'b00;
    localparam logic [1:0] OP_MULT  = 2'b01;
    localparam logic [1:0] OP_MTHI  = 2'b10;
    localparam logic [1:0] OP_MTLO  = 2'b11;

    localparam logic [3:0] LAT_CNT = 4'(LATENCY);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [3:0]  cnt;
    logic        neg;
    logic        idle_op;
    logic        issue_mul;
    logic        is_signed;
    logic [31:0] rs_mag;
    logic [31:0] rt_mag;
    logic [63:0] product_fix;

    // Requests are only honoured in IDLE; the pipeline holds them while busy.
    assign idle_op   = (state == ST_IDLE) && op_valid;
    assign issue_mul = idle_op && (op == OP_MULTU || op == OP_MULT);
    assign is_signed = (op == OP_MULT);

    // Two's-complement magnitude; 0x80000000 maps to itself, which is the
    // correct unsigned magnitude.
    assign rs_mag = rs_val[31] ? (~rs_val + 32'd1) : rs_val;
    assign rt_mag = rt_val[31] ? (~rt_val + 32'd1) : rt_val;

    // Negation is mod 2^64, so a zero product stays zero.
    assign product_fix = neg ? (~core_z + 64'd1) : core_z;

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (issue_mul) state_nxt = ST_WAIT;
            ST_WAIT:   if (cnt <= 4'd1) state_nxt = ST_COMMIT;
            ST_COMMIT: state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    // busy is registered so it rises the clock after issue and falls the
    // clock after commit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) busy <= 1'b0;
        else       busy <= (state_nxt != ST_IDLE);
    end

    // Operand capture and latency counter; operands stay put through WAIT.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            core_a <= 32'd0;
            core_b <= 32'd0;
            neg    <= 1'b0;
            cnt    <= 4'd0;
        end else if (issue_mul) begin
            core_a <= is_signed ? rs_mag : rs_val;
            core_b <= is_signed ? rt_mag : rt_val;
            neg    <= is_signed && (rs_val[31] ^ rt_val[31]);
            cnt    <= LAT_CNT;
        end else if (state == ST_WAIT && cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
        end
    end

    // HI/LO: product commit, or direct moves from rs while idle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hi <= 32'd0;
            lo <= 32'd0;
        end else if (state == ST_COMMIT) begin
            hi <= product_fix[63:32];
            lo <= product_fix[31:0];
        end else if (idle_op && op == OP_MTHI) begin
            hi <= rs_val;
        end else if (idle_op && op == OP_MTLO) begin
            lo <= rs_val;
        end
    end

endmodule

// File: tb/tb_hilo_mult_unit.sv
`timescale 1ns/1ps
// Bench for hilo_mult_unit: a LATENCY=1 instance checked through a
// scoreboard, plus a LATENCY=4 instance for commit timing and mid-WAIT reset.
module tb_hilo_mult_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // LATENCY=1 instance
    logic        reset1, v1;
    logic [1:0]  op1;
    logic [31:0] rs1, rt1, ca1, cb1, hi1, lo1;
    logic [63:0] z1;
    logic        busy1;

    hilo_mult_unit #(.LATENCY(1)) dut1 (
        .clk(clk), .reset(reset1), .op_valid(v1), .op(op1),
        .rs_val(rs1), .rt_val(rt1), .core_a(ca1), .core_b(cb1),
        .core_z(z1), .busy(busy1), .hi(hi1), .lo(lo1)
    );

    // LATENCY=4 instance
    logic        reset4, v4;
    logic [1:0]  op4;
    logic [31:0] rs4, rt4, ca4, cb4, hi4, lo4;
    logic [63:0] z4;
    logic        busy4;

    hilo_mult_unit #(.LATENCY(4)) dut4 (
        .clk(clk), .reset(reset4), .op_valid(v4), .op(op4),
        .rs_val(rs4), .rt_val(rt4), .core_a(ca4), .core_b(cb4),
        .core_z(z4), .busy(busy4), .hi(hi4), .lo(lo4)
    );

    // Core models: product emerges exactly LATENCY clocks after operands.
    logic [63:0] p4 [4];
    initial begin
        z1 = 64'd0;
        for (int i = 0; i < 4; i++) p4[i] = 64'd0;
    end
    always @(posedge clk) z1 <= 64'(ca1) * 64'(cb1);
    always @(posedge clk) begin
        p4[0] <= 64'(ca4) * 64'(cb4);
        p4[1] <= p4[0];
        p4[2] <= p4[1];
        p4[3] <= p4[2];
    end
    assign z4 = p4[3];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Scoreboard
    typedef struct {
        logic        mul;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    exp_t        sbq[$];
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    // Reference model: plain signed/unsigned 64-bit arithmetic.
    task automatic push_expect(input logic [1:0] op, input logic [31:0] rs, input logic [31:0] rt);
        exp_t   e;
        longint ls, lt;
        logic [63:0] p;
        ls = longint'($signed(rs));
        lt = longint'($signed(rt));
        e.mul = 1'b0; e.a = 32'd0; e.b = 32'd0;
        case (op)
            2'b00: begin
                p = 64'(rs) * 64'(rt);
                e.mul = 1'b1; e.a = rs; e.b = rt;
                m_hi = p[63:32]; m_lo = p[31:0];
            end
            2'b01: begin
                p = 64'(ls * lt);
                e.mul = 1'b1;
                e.a = (ls < 0) ? 32'(-ls) : rs;
                e.b = (lt < 0) ? 32'(-lt) : rt;
                m_hi = p[63:32]; m_lo = p[31:0];
            end
            2'b10: m_hi = rs;
            default: m_lo = rs;
        endcase
        e.hi = m_hi;
        e.lo = m_lo;
        sbq.push_back(e);
    endtask

    // Issue one op to dut1 once it is idle; called at a negedge.
    task automatic issue1(input logic [1:0] op, input logic [31:0] rs, input logic [31:0] rt);
        int guard = 0;
        while (busy1 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (busy1) check("issue_wait_timeout", 64'(busy1), 64'd0);
        v1 = 1'b1; op1 = op; rs1 = rs; rt1 = rt;
        push_expect(op, rs, rt);
        @(negedge clk);
        v1 = 1'b0;
    endtask

    // Present an op while busy; it must be ignored, so nothing is expected.
    task automatic pulse_ignored1(input logic [1:0] op, input logic [31:0] rs, input logic [31:0] rt);
        v1 = 1'b1; op1 = op; rs1 = rs; rt1 = rt;
        @(negedge clk);
        v1 = 1'b0;
    endtask

    // Monitor for dut1
    logic acc_mt1 = 1'b0;
    always @(posedge clk) acc_mt1 <= v1 && !busy1 && op1[1] && !reset1;

    initial begin
        logic        prev_busy = 1'b0;
        int          bcnt = 0;
        logic [31:0] mon_hi = 32'd0;
        logic [31:0] mon_lo = 32'd0;
        exp_t        e;
        forever begin
            @(negedge clk);
            if (reset1) begin
                prev_busy = 1'b0;
                bcnt = 0;
                mon_hi = 32'd0;
                mon_lo = 32'd0;
            end else begin
                if (busy1) begin
                    bcnt++;
                    check("hilo_held_during_busy", {hi1, lo1}, {mon_hi, mon_lo});
                    if (!prev_busy) begin
                        if (sbq.size() == 0) begin
                            check("busy_without_issue", 64'd1, 64'd0);
                        end else begin
                            check("core_a", 64'(ca1), 64'(sbq[0].a));
                            check("core_b", 64'(cb1), 64'(sbq[0].b));
                        end
                    end
                end
                if (prev_busy && !busy1) begin
                    if (sbq.size() == 0) begin
                        check("commit_underflow", 64'd1, 64'd0);
                    end else begin
                        e = sbq.pop_front();
                        check("commit_is_mul", 64'(e.mul), 64'd1);
                        check("commit_hilo", {hi1, lo1}, {e.hi, e.lo});
                        check("busy_cycles", 64'(bcnt), 64'd2);
                        mon_hi = e.hi; mon_lo = e.lo;
                    end
                    bcnt = 0;
                end
                if (acc_mt1) begin
                    if (sbq.size() == 0) begin
                        check("move_underflow", 64'd1, 64'd0);
                    end else begin
                        e = sbq.pop_front();
                        check("move_is_mt", 64'(e.mul), 64'd0);
                        check("move_hilo", {hi1, lo1}, {e.hi, e.lo});
                        check("move_busy", 64'(busy1), 64'd0);
                        mon_hi = e.hi; mon_lo = e.lo;
                    end
                end
                prev_busy = busy1;
            end
        end
    end

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 5))
            0: return 32'h8000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'd0;
            3: return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int guard;
        reset1 = 1'b1; reset4 = 1'b1;
        v1 = 1'b0; op1 = 2'b00; rs1 = 32'd0; rt1 = 32'd0;
        v4 = 1'b0; op4 = 2'b00; rs4 = 32'd0; rt4 = 32'd0;
        #1;
        check("rst_busy", 64'(busy1), 64'd0);
        check("rst_hilo", {hi1, lo1}, 64'd0);
        check("rst_core", {ca1, cb1}, 64'd0);
        check("rst4_hilo", {hi4, lo4}, 64'd0);
        @(negedge clk);
        @(negedge clk);
        reset1 = 1'b0; reset4 = 1'b0;
        @(negedge clk);

        // Directed cases on the LATENCY=1 instance
        issue1(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        issue1(2'b01, 32'hFFFF_FFFE, 32'd3);
        issue1(2'b01, 32'h8000_0000, 32'h8000_0000);
        issue1(2'b01, 32'h8000_0000, 32'd1);
        issue1(2'b10, 32'h1234_5678, 32'd0);
        issue1(2'b11, 32'h9ABC_DEF0, 32'd0);
        issue1(2'b01, 32'hFFFF_FFF9, 32'd0);
        pulse_ignored1(2'b00, 32'h0000_1234, 32'h0000_5678);
        issue1(2'b00, 32'd5, 32'd7);
        pulse_ignored1(2'b10, 32'hDEAD_BEEF, 32'd0);
        issue1(2'b01, 32'd6, 32'hFFFF_FFFF);

        // Randomized ops
        for (int i = 0; i < 60; i++) begin
            issue1(2'($urandom_range(0, 3)), rand_operand(), rand_operand());
            if ($urandom_range(0, 3) == 0 && busy1)
                pulse_ignored1(2'($urandom_range(0, 3)), $urandom, $urandom);
        end

        guard = 0;
        while ((sbq.size() != 0 || busy1) && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        check("drain_queue_empty", 64'(sbq.size()), 64'd0);

        // LATENCY=4: commit timing
        v4 = 1'b1; op4 = 2'b00; rs4 = 32'h0001_0000; rt4 = 32'h0003_0000;
        @(negedge clk);
        v4 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("l4_busy_in_flight", 64'(busy4), 64'd1);
            check("l4_hilo_held", {hi4, lo4}, 64'd0);
            @(negedge clk);
        end
        check("l4_busy_done", 64'(busy4), 64'd0);
        check("l4_commit", {hi4, lo4}, 64'h0000_0003_0000_0000);

        // LATENCY=4: reset mid-WAIT aborts the operation
        v4 = 1'b1; op4 = 2'b01; rs4 = 32'hFFFF_FFF0; rt4 = 32'h0000_0100;
        @(negedge clk);
        v4 = 1'b0;
        @(negedge clk);
        #2 reset4 = 1'b1;
        #1;
        check("l4_rst_busy", 64'(busy4), 64'd0);
        check("l4_rst_hilo", {hi4, lo4}, 64'd0);
        check("l4_rst_core", {ca4, cb4}, 64'd0);
        @(negedge clk);
        reset4 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("l4_no_late_commit", {31'd0, busy4, hi4, lo4}, 64'd0);
        end
        v4 = 1'b1; op4 = 2'b11; rs4 = 32'h0000_A5A5;
        @(negedge clk);
        v4 = 1'b0;
        check("l4_idle_after_reset", {31'd0, busy4, hi4, lo4}, 64'h0000_0000_0000_A5A5);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
